// File: rtl/packet_sorter.sv
// Receive-side data-island packet dispatcher: audio samples into a stereo FIFO,
// ACR into N/CTS registers, AVI InfoFrames checksum-verified and captured.
module packet_sorter #(
  parameter int unsigned AUDIO_BIT_WIDTH    = 16,
  parameter int unsigned FIFO_DEPTH         = 8,
  parameter int unsigned AVI_TIMEOUT_FIELDS = 2
) (
  input  logic                       clk_pixel,
  input  logic                       reset,
  input  logic                       packet_valid,
  input  logic [23:0]                packet_header,
  input  logic [3:0][55:0]           packet_sub,
  input  logic                       packet_ecc_ok,
  input  logic                       video_field_end,
  input  logic                       audio_ready,
  output logic                       audio_valid,
  output logic [AUDIO_BIT_WIDTH-1:0] audio_left,
  output logic [AUDIO_BIT_WIDTH-1:0] audio_right,
  output logic                       audio_block_start,
  output logic                       audio_overflow,
  output logic                       acr_update,
  output logic [19:0]                acr_n,
  output logic [19:0]                acr_cts,
  output logic                       avi_valid,
  output logic [6:0]                 avi_vic,
  output logic [1:0]                 avi_rgb_range,
  output logic [7:0]                 ecc_error_count,
  output logic [7:0]                 checksum_error_count
);

  localparam int unsigned AW = AUDIO_BIT_WIDTH;
  localparam int unsigned SW = 2 * AW;
  localparam int unsigned EW = SW + 1;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned FW = $clog2(AVI_TIMEOUT_FIELDS + 1);

  typedef enum logic [0:0] {ST_IDLE, ST_UNPACK} state_e;

  logic [7:0] hb0, hb1, hb2;
  assign hb0 = packet_header[7:0];
  assign hb1 = packet_header[15:8];
  assign hb2 = packet_header[23:16];

  logic pkt_ok_c, is_acr_c, is_audio_c, is_avi_c;
  assign pkt_ok_c   = packet_valid & packet_ecc_ok;
  assign is_acr_c   = (hb0 == 8'h01);
  assign is_audio_c = (hb0 == 8'h02);
  assign is_avi_c   = (hb0 == 8'h82);

  // InfoFrame checksum over the three header bytes and all 28 subpacket bytes
  logic [7:0] avi_sum_c;
  always_comb begin
    avi_sum_c = hb0 + hb1 + hb2;
    for (int i = 0; i < 4; i++) begin
      for (int b = 0; b < 7; b++) begin
        avi_sum_c = avi_sum_c + packet_sub[i][8*b +: 8];
      end
    end
  end

  // ---------------- audio unpacker ----------------
  state_e              state_q, state_d;
  logic [3:0]          mask_q, mask_d;
  logic [3:0]          bflag_q, bflag_d;
  logic [3:0][SW-1:0]  smp_q, smp_d;
  logic [1:0]          idx_c;
  logic                wr_req_c;
  logic [EW-1:0]       wdata_c;
  logic                audio_start_c;
  logic                audio_clash_c;

  assign audio_start_c = pkt_ok_c & is_audio_c & (state_q == ST_IDLE) & (hb1[3:0] != 4'b0);
  assign audio_clash_c = pkt_ok_c & is_audio_c & (state_q == ST_UNPACK);

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    bflag_d  = bflag_q;
    smp_d    = smp_q;
    wr_req_c = 1'b0;
    idx_c    = 2'd0;
    // lowest still-present subpacket goes next, so absent ones cost no cycle
    for (int i = 3; i >= 0; i--) begin
      if (mask_q[i]) idx_c = 2'(i);
    end
    wdata_c = {bflag_q[idx_c], smp_q[idx_c]};
    case (state_q)
      ST_IDLE: begin
        if (audio_start_c) begin
          mask_d  = hb1[3:0];
          bflag_d = hb2[7:4];
          for (int i = 0; i < 4; i++) begin
            smp_d[i] = {packet_sub[i][47 -: AW], packet_sub[i][23 -: AW]};
          end
          state_d = ST_UNPACK;
        end
      end
      ST_UNPACK: begin
        wr_req_c = 1'b1;
        mask_d   = mask_q & ~(4'b0001 << idx_c);
        if (mask_d == 4'b0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      bflag_q <= '0;
      smp_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      bflag_q <= bflag_d;
      smp_q   <= smp_d;
    end
  end

  // ---------------- audio FIFO with registered head ----------------
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [EW-1:0] head_q, head_d;
  logic          valid_q, valid_d, ovf_q, ovf_d;
  logic          rd_c, wr_c, full_c;

  always_comb begin
    rd_c     = valid_q & audio_ready;
    full_c   = (count_q == CW'(FIFO_DEPTH));
    wr_c     = wr_req_c & (~full_c | rd_c);
    rd_ptr_d = rd_ptr_q + PW'(rd_c);
    wr_ptr_d = wr_ptr_q + PW'(wr_c);
    count_d  = count_q + CW'(wr_c) - CW'(rd_c);
    valid_d  = (count_d != '0);
    ovf_d    = ovf_q | (wr_req_c & full_c & ~rd_c);
    head_d   = head_q;
    // an entry being written into an otherwise-empty FIFO bypasses the array
    if (count_d != '0) begin
      head_d = (wr_c && (wr_ptr_q == rd_ptr_d)) ? wdata_c : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (wr_c) mem_q[wr_ptr_q] <= wdata_c;
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  // ---------------- ACR, AVI, field timeout, error counters ----------------
  logic [19:0]   acr_n_q, acr_n_d, acr_cts_q, acr_cts_d;
  logic          acr_upd_q, acr_upd_d;
  logic          avi_valid_q, avi_valid_d;
  logic [6:0]    vic_q, vic_d;
  logic [1:0]    rgb_q, rgb_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [7:0]    ecc_cnt_q, ecc_cnt_d, cks_cnt_q, cks_cnt_d;
  logic          avi_good_c, cks_err_c;

  assign avi_good_c = pkt_ok_c & is_avi_c & (avi_sum_c == 8'h00);
  assign cks_err_c  = (pkt_ok_c & is_avi_c & (avi_sum_c != 8'h00)) | audio_clash_c;

  always_comb begin
    acr_upd_d = pkt_ok_c & is_acr_c;
    acr_n_d   = acr_n_q;
    acr_cts_d = acr_cts_q;
    if (acr_upd_d) begin
      acr_cts_d = {packet_sub[0][11:8], packet_sub[0][23:16], packet_sub[0][31:24]};
      acr_n_d   = {packet_sub[0][35:32], packet_sub[0][47:40], packet_sub[0][55:48]};
    end
    avi_valid_d = avi_valid_q;
    vic_d       = vic_q;
    rgb_d       = rgb_q;
    fcnt_d      = fcnt_q;
    if (avi_good_c) begin
      avi_valid_d = 1'b1;
      vic_d       = packet_sub[0][38:32];
      rgb_d       = packet_sub[0][27:26];
      fcnt_d      = '0;
    end else if (video_field_end) begin
      if (fcnt_q != FW'(AVI_TIMEOUT_FIELDS)) fcnt_d = fcnt_q + FW'(1);
      if (fcnt_d == FW'(AVI_TIMEOUT_FIELDS)) avi_valid_d = 1'b0;
    end
    ecc_cnt_d = ecc_cnt_q;
    if (packet_valid && !packet_ecc_ok && ecc_cnt_q != 8'hFF) ecc_cnt_d = ecc_cnt_q + 8'd1;
    cks_cnt_d = cks_cnt_q;
    if (cks_err_c && cks_cnt_q != 8'hFF) cks_cnt_d = cks_cnt_q + 8'd1;
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      acr_n_q     <= '0;
      acr_cts_q   <= '0;
      acr_upd_q   <= 1'b0;
      avi_valid_q <= 1'b0;
      vic_q       <= '0;
      rgb_q       <= '0;
      fcnt_q      <= '0;
      ecc_cnt_q   <= '0;
      cks_cnt_q   <= '0;
    end else begin
      acr_n_q     <= acr_n_d;
      acr_cts_q   <= acr_cts_d;
      acr_upd_q   <= acr_upd_d;
      avi_valid_q <= avi_valid_d;
      vic_q       <= vic_d;
      rgb_q       <= rgb_d;
      fcnt_q      <= fcnt_d;
      ecc_cnt_q   <= ecc_cnt_d;
      cks_cnt_q   <= cks_cnt_d;
    end
  end

  assign audio_valid          = valid_q;
  assign audio_block_start    = head_q[EW-1];
  assign audio_right          = head_q[SW-1:AW];
  assign audio_left           = head_q[AW-1:0];
  assign audio_overflow       = ovf_q;
  assign acr_update           = acr_upd_q;
  assign acr_n                = acr_n_q;
  assign acr_cts              = acr_cts_q;
  assign avi_valid            = avi_valid_q;
  assign avi_vic              = vic_q;
  assign avi_rgb_range        = rgb_q;
  assign ecc_error_count      = ecc_cnt_q;
  assign checksum_error_count = cks_cnt_q;

endmodule

// File: doc/packet_sorter.md
# packet_sorter

Receive-side counterpart of the HDMI data-island packet picker. It takes decoded 32-pixel data-island packets (header plus four subpackets, after BCH correction) and dispatches them by type. Audio Sample packets are unpacked into a stereo sample FIFO. Audio Clock Regeneration packets update N/CTS registers. AVI InfoFrames are checksum-verified and their fields captured. All other types are discarded. It sits between the TERC4 data-island decoder and the audio/video sink logic, in the clk_pixel domain.

## Interface
- AUDIO_BIT_WIDTH, 16: output sample width, 16..24; outputs carry the top bits [23:24-AUDIO_BIT_WIDTH] of each 24-bit received sample.
- FIFO_DEPTH, 8: audio FIFO entries; power of two, ≥4.
- AVI_TIMEOUT_FIELDS, 2: number of field ends without a valid AVI before avi_valid drops.
- clk_pixel  in  1  pixel clock.
- reset  in  1  synchronous, active-high.
- packet_valid  in  1  one-cycle strobe; the packet fields are valid this cycle.
- packet_header  in  24  {HB2, HB1, HB0}.
- packet_sub  in  4x56  subpacket i = {SB6..SB0}.
- packet_ecc_ok  in  1  all BCH blocks of the packet passed.
- video_field_end  in  1  one-cycle strobe per field.
- audio_ready  in  1  downstream accepts a sample.
- audio_valid  out  1  audio FIFO head valid.
- audio_left, audio_right  out  AUDIO_BIT_WIDTH  FIFO head sample.
- audio_block_start  out  1  IEC 60958 B flag of the head sample.
- audio_overflow  out  1  sticky; set when a sample is dropped because the FIFO is full.
- acr_update  out  1  one-cycle pulse when new N/CTS values are loaded.
- acr_n, acr_cts  out  20  last received N and CTS.
- avi_valid  out  1  a valid AVI InfoFrame has been received within the timeout window.
- avi_vic  out  7  PB4[6:0].
- avi_rgb_range  out  2  PB3[3:2].
- ecc_error_count, checksum_error_count  out  8  saturating error counters.

## Operation
- Reset: all outputs are 0; FIFO empty; state IDLE; field counter 0.
- A packet with packet_ecc_ok=0 is dropped, and ecc_error_count increments, saturating at 255.
- HB0=0x01 (ACR): CTS = {sub0[11:8], sub0[23:16], sub0[31:24]}; N = {sub0[35:32], sub0[47:40], sub0[55:48]}. Both are loaded and acr_update pulses.
- HB0=0x02 (audio):
  - The unpacker latches the packet and moves IDLE→UNPACK, then walks i=0..3.
  - For each i with HB1[i]=1, one FIFO write per cycle of {sub_i[47:24] (right), sub_i[23:0] (left), HB2[4+i] (B flag)}. Subpackets with HB1[i]=0 are skipped without consuming a cycle.
  - The unpacker returns to IDLE after the last present sample. HB1[3:0]=0 does nothing.
  - Arrival at the FIFO write when full: the sample is dropped, audio_overflow is set, and the remaining samples continue.
- HB0=0x82 (AVI):
  - Checksum = 8-bit sum of HB0..HB2 and all 28 subpacket bytes. It must equal 0; otherwise checksum_error_count increments and nothing is captured.
  - When valid: avi_vic = sub0[38:32], avi_rgb_range = sub0[27:26], avi_valid = 1, field counter cleared.
- Field timeout:
  - Each video_field_end increments the field counter, saturating.
  - When the count reaches AVI_TIMEOUT_FIELDS, avi_valid clears. avi_vic and avi_rgb_range hold their values.
  - A valid AVI in the same cycle as video_field_end wins: the counter goes to 0 and avi_valid stays 1.
- packet_valid while in UNPACK: the new packet is processed normally only if it is not audio. An audio packet arriving then is dropped and counted in checksum_error_count; upstream guarantees a ≥32-cycle spacing, so this indicates a protocol error.
- Other HB0 values, including 0x00 (NULL): ignored.
- The FIFO is synchronous with registered head outputs. A read occurs when audio_valid & audio_ready. A simultaneous read and write on a full FIFO succeeds with no drop.

## Timing
- ACR and AVI outputs and acr_update: valid on the cycle after packet_valid (1-cycle latency).
- First audio FIFO write: the cycle after packet_valid. The k-th present sample is written at cycle k.
- audio_valid: asserts 1 cycle after the write into an empty FIFO, i.e. 2 cycles after packet_valid.
- Error counters: update 1 cycle after the event.
- Reset mid-UNPACK: remaining samples are abandoned; FIFO and all outputs return to reset values on the next cycle.

## Test plan
- ACR with CTS=0x1_2345, N=0x0_1800 → acr_cts=0x12345, acr_n=0x01800, and one acr_update pulse 1 cycle later.
- Audio packet with HB1=0b1011, HB2[7:4]=0b0001, samples L=0x1111_00·i, R=0x2222_00·i, audio_ready=1 → three outputs in order i=0,1,3 on consecutive cycles starting 2 cycles after packet_valid; block_start=1 only on i=0; 16-bit outputs 0x1111, 0x2222.
- Hold audio_ready=0 and send three 4-sample packets with FIFO_DEPTH=8 → 8 samples retained, audio_overflow=1, then draining yields exactly the first 8 samples.
- AVI with VIC=16, PB3=0x08, correct checksum → avi_valid=1, avi_vic=16, avi_rgb_range=2. Corrupt one byte → no update, checksum_error_count +1.
- After a valid AVI, two video_field_end pulses → avi_valid=0. An AVI coincident with the second field end → avi_valid stays 1.
- packet_ecc_ok=0 on an ACR packet → N/CTS unchanged, ecc_error_count +1. After 300 such packets the counter reads 255.
